// File: rtl/store_buffer_m_if.sv
// -----------------------------------------------------------------------------
// store_buffer_m_if
// Bundles every non-clock, non-reset signal of the store buffer.
//   Pipeline store side : st_valid, st_addr, st_data -> st_ready
//   Load forwarding     : ld_addr -> ld_hit, ld_data
//   Data memory side    : mem_WE, mem_addr, mem_DataI <- mem_ack
//   Status              : count, empty, full
// slave  : the store buffer itself.
// master : the environment (pipeline + data memory).
// -----------------------------------------------------------------------------
interface store_buffer_m_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                   st_valid;
    logic [AW-1:0]          st_addr;
    logic [DW-1:0]          st_data;
    logic                   st_ready;
    logic [AW-1:0]          ld_addr;
    logic                   ld_hit;
    logic [DW-1:0]          ld_data;
    logic                   mem_WE;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_DataI;
    logic                   mem_ack;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_ack,
        output st_ready, ld_hit, ld_data, mem_WE, mem_addr, mem_DataI,
               count, empty, full
    );

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_ack,
        input  st_ready, ld_hit, ld_data, mem_WE, mem_addr, mem_DataI,
               count, empty, full
    );
endinterface

// File: rtl/store_buffer_m.sv
// -----------------------------------------------------------------------------
// store_buffer_m
// DEPTH-entry FIFO of pending word stores between the pipeline and data memory.
// Stores are accepted while not full, drained in order to memory one per
// mem_ack, and buffered data is forwarded to same-word loads (youngest wins).
// Ports:
//   ref_clk : rising-edge clock
//   rst_n   : asynchronous active-low reset, discards all pending stores
//   bus     : store_buffer_m_if.slave (store, load-forward, memory, status)
// -----------------------------------------------------------------------------
module store_buffer_m #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    store_buffer_m_if.slave       bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    // Only word addresses are kept; byte offset bits never matter.
    logic [AW-3:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];

    logic            empty_w, full_w, push, pop;
    logic            hit_w;
    logic [DW-1:0]   fwd_w;
    logic [PW-1:0]   fwd_idx;
    logic            unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

    // Occupancy alone decides full/empty since pointers carry no wrap bit.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    // No push-through-pop when full: acceptance depends on count only.
    assign push = bus.st_valid && !full_w;
    assign pop  = bus.mem_ack && !empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Entry payload needs no reset: it is qualified by vld_q / count_q.
    always_ff @(posedge ref_clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.st_addr[AW-1:2];
            data_q[wr_ptr_q] <= bus.st_data;
        end
    end

    // Walk from oldest (rd_ptr) to youngest so a later match overrides.
    // A store being pushed is not yet valid, so it cannot forward this cycle.
    always_comb begin
        hit_w   = 1'b0;
        fwd_w   = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if (vld_q[fwd_idx] && (addr_q[fwd_idx] == bus.ld_addr[AW-1:2])) begin
                hit_w = 1'b1;
                fwd_w = data_q[fwd_idx];
            end
        end
    end

    assign bus.st_ready  = !full_w;
    assign bus.mem_WE    = !empty_w;
    assign bus.mem_addr  = empty_w ? '0 : {addr_q[rd_ptr_q], 2'b00};
    assign bus.mem_DataI = empty_w ? '0 : data_q[rd_ptr_q];
    assign bus.ld_hit    = hit_w;
    assign bus.ld_data   = fwd_w;
    assign bus.count     = count_q;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
endmodule

// File: tb/tb_store_buffer_m.sv
module tb_store_buffer_m;
    localparam int DEPTH = 4;

    logic ref_clk = 1'b0;
    logic rst_n   = 1'b0;

    store_buffer_m_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) sb_if ();

    store_buffer_m #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .bus     (sb_if.slave)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the queue-based reference model.
    task automatic check_model(input string tag);
        logic        e_hit;
        logic [31:0] e_fwd;
        e_hit = 1'b0;
        e_fwd = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!e_hit && q[i].a[31:2] == sb_if.ld_addr[31:2]) begin
                e_hit = 1'b1;
                e_fwd = q[i].d;
            end
        end
        check_val({tag, ".st_ready"}, 64'(sb_if.st_ready), 64'(q.size() != DEPTH));
        check_val({tag, ".count"},    64'(sb_if.count),    64'(q.size()));
        check_val({tag, ".empty"},    64'(sb_if.empty),    64'(q.size() == 0));
        check_val({tag, ".full"},     64'(sb_if.full),     64'(q.size() == DEPTH));
        check_val({tag, ".mem_WE"},   64'(sb_if.mem_WE),   64'(q.size() != 0));
        check_val({tag, ".mem_addr"}, 64'(sb_if.mem_addr),
                  (q.size() != 0) ? 64'({q[0].a[31:2], 2'b00}) : 64'd0);
        check_val({tag, ".mem_DataI"}, 64'(sb_if.mem_DataI),
                  (q.size() != 0) ? 64'(q[0].d) : 64'd0);
        check_val({tag, ".ld_hit"},  64'(sb_if.ld_hit),  64'(e_hit));
        check_val({tag, ".ld_data"}, 64'(sb_if.ld_data), 64'(e_fwd));
    endtask

    // Drive one cycle: inputs set at posedge+1, checked before the edge,
    // model updated at the edge; returns at the following posedge+1.
    task automatic cycle(input string tag, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic ack, input logic [31:0] la);
        logic do_push, do_pop;
        ent_t e;
        sb_if.st_valid = v;
        sb_if.st_addr  = a;
        sb_if.st_data  = d;
        sb_if.mem_ack  = ack;
        sb_if.ld_addr  = la;
        #2;
        check_model(tag);
        do_push = v && (q.size() < DEPTH);
        do_pop  = ack && (q.size() > 0);
        @(posedge ref_clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
        #1;
    endtask

    initial begin
        sb_if.st_valid = 1'b0;
        sb_if.st_addr  = '0;
        sb_if.st_data  = '0;
        sb_if.mem_ack  = 1'b0;
        sb_if.ld_addr  = '0;

        // Reset
        #1;
        check_val("rst.count",    64'(sb_if.count),    64'd0);
        check_val("rst.empty",    64'(sb_if.empty),    64'd1);
        check_val("rst.st_ready", 64'(sb_if.st_ready), 64'd1);
        check_val("rst.mem_WE",   64'(sb_if.mem_WE),   64'd0);
        check_val("rst.ld_hit",   64'(sb_if.ld_hit),   64'd0);
        repeat (3) @(posedge ref_clk);
        @(negedge ref_clk);
        rst_n = 1'b1;
        @(posedge ref_clk);
        #1;
        check_model("post_rst");

        // Single store held for 3 cycles without ack, then acked
        cycle("ss_push", 1'b1, 32'h10, 32'h7FF, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check_val("ss.mem_WE",    64'(sb_if.mem_WE),    64'd1);
            check_val("ss.mem_addr",  64'(sb_if.mem_addr),  64'h10);
            check_val("ss.mem_DataI", 64'(sb_if.mem_DataI), 64'h7FF);
            cycle("ss_hold", 1'b0, 32'h0, 32'h0, (i == 3), 32'h0);
        end
        check_val("ss.empty_after",  64'(sb_if.empty),  64'd1);
        check_val("ss.mem_WE_after", 64'(sb_if.mem_WE), 64'd0);

        // Fill and overflow
        for (int i = 0; i < 4; i++)
            cycle("fill", 1'b1, 32'(i * 4), 32'(i + 1), 1'b0, 32'h100);
        check_val("fill.full",     64'(sb_if.full),     64'd1);
        check_val("fill.st_ready", 64'(sb_if.st_ready), 64'd0);
        check_val("fill.count",    64'(sb_if.count),    64'd4);
        check_val("fill.head1",    64'(sb_if.mem_DataI), 64'd1);
        cycle("ovf", 1'b1, 32'h40, 32'h5, 1'b1, 32'h100);
        check_val("ovf.count", 64'(sb_if.count), 64'd3);
        for (int k = 2; k <= 4; k++) begin
            check_val("drain.order", 64'(sb_if.mem_DataI), 64'(k));
            cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
        end
        check_val("drain.empty", 64'(sb_if.empty), 64'd1);

        // Simultaneous push/pop with pointer wrap
        cycle("wrap_pre", 1'b1, 32'h80, 32'h100, 1'b0, 32'h0);
        cycle("wrap_pre", 1'b1, 32'h84, 32'h101, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle("wrap", 1'b1, 32'(32'h88 + i * 4), 32'(32'h102 + i), 1'b1, 32'h0);
            check_val("wrap.count", 64'(sb_if.count), 64'd2);
        end
        check_val("wrap.head", 64'(sb_if.mem_DataI), 64'h108);
        while (q.size() != 0) cycle("wrap_drain", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        // Forwarding
        cycle("fw_push", 1'b1, 32'h20, 32'hA, 1'b0, 32'h20);
        cycle("fw_push", 1'b1, 32'h20, 32'hB, 1'b0, 32'h20);
        cycle("fw_push", 1'b1, 32'h24, 32'hC, 1'b0, 32'h24);
        cycle("fw_ld23", 1'b0, 32'h0, 32'h0, 1'b0, 32'h23);
        check_val("fw.hit23",  64'(sb_if.ld_hit),  64'd1);
        check_val("fw.data23", 64'(sb_if.ld_data), 64'hB);
        cycle("fw_ld28", 1'b0, 32'h0, 32'h0, 1'b0, 32'h28);
        check_val("fw.hit28",  64'(sb_if.ld_hit),  64'd0);
        check_val("fw.data28", 64'(sb_if.ld_data), 64'h0);
        while (q.size() != 0) cycle("fw_drain", 1'b0, 32'h0, 32'h0, 1'b1, 32'h20);

        // Reset mid-drain
        for (int i = 0; i < 3; i++)
            cycle("rd_push", 1'b1, 32'(32'h200 + i * 4), 32'(32'h50 + i), 1'b0, 32'h200);
        check_val("rd.mem_WE_before", 64'(sb_if.mem_WE), 64'd1);
        sb_if.st_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_val("rd.mem_WE", 64'(sb_if.mem_WE), 64'd0);
        check_val("rd.count",  64'(sb_if.count),  64'd0);
        check_val("rd.ld_hit", 64'(sb_if.ld_hit), 64'd0);
        @(negedge ref_clk);
        rst_n = 1'b1;
        @(posedge ref_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            cycle("rd_after", 1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
            check_val("rd.no_write", 64'(sb_if.mem_WE), 64'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rd, rl;
            ra = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            rl = 32'(($urandom_range(0, 8) << 2) | $urandom_range(0, 3));
            rd = $urandom;
            cycle("rand", ($urandom_range(0, 99) < 60), ra, rd,
                  ($urandom_range(0, 99) < 45), rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
